// File: rtl/peripheral_mult_n.sv
// Memory-mapped W x W sequential multiplier on the J1 I/O bus.
// Radix-2 shift-add engine on operand magnitudes, sign fixed up in FINISH.
module peripheral_mult_n #(
  parameter int unsigned W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned PW = 2 * W;

  localparam logic [4:0] ADDR_A      = 5'h04;
  localparam logic [4:0] ADDR_B      = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h0C;
  localparam logic [4:0] ADDR_RES_LO = 5'h10;
  localparam logic [4:0] ADDR_RES_HI = 5'h14;
  localparam logic [4:0] ADDR_STATUS = 5'h18;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state;
  logic [W-1:0]    a_reg, b_reg;
  logic [W-1:0]    mcand;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            sgn_mode, neg;
  logic [63:0]     res;
  logic            done, err;

  logic            busy_c, wr_en_c, rd_en_c, start_sgn_c, reg_wr_c;
  logic [W-1:0]    a_mag_c, b_mag_c;
  logic [W:0]      sum_c;
  logic [PW-1:0]   prod_c;
  logic [63:0]     res_ext_c;
  logic [31:0]     rdata_c;
  logic            unused_d_in;

  assign busy_c      = (state != IDLE);
  assign wr_en_c     = cs & wr;
  assign rd_en_c     = cs & rd;
  assign start_sgn_c = d_in[1];
  assign reg_wr_c    = wr_en_c & ((addr == ADDR_A) | (addr == ADDR_B) | (addr == ADDR_CTRL));
  assign unused_d_in = ^d_in;

  // Magnitudes for the start that is being written right now; W-bit so -2^(W-1) stays 2^(W-1)
  assign a_mag_c = (start_sgn_c && a_reg[W-1]) ? W'(-a_reg) : a_reg;
  assign b_mag_c = (start_sgn_c && b_reg[W-1]) ? W'(-b_reg) : b_reg;

  // Add into the upper half with carry out, then shift the whole accumulator right
  assign sum_c = {1'b0, acc[PW-1:W]} + (acc[0] ? {1'b0, mcand} : '0);

  assign prod_c    = neg ? PW'(-acc) : acc;
  assign res_ext_c = sgn_mode ? 64'($signed(prod_c)) : 64'(prod_c);

  always_comb begin
    rdata_c = '0;
    case (addr)
      ADDR_A:      rdata_c = 32'(a_reg);
      ADDR_B:      rdata_c = 32'(b_reg);
      ADDR_RES_LO: rdata_c = res[31:0];
      ADDR_RES_HI: rdata_c = res[63:32];
      ADDR_STATUS: rdata_c = {29'b0, err, done, busy_c};
      default:     rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      mcand    <= '0;
      acc      <= '0;
      count    <= '0;
      sgn_mode <= 1'b0;
      neg      <= 1'b0;
      res      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      d_out    <= '0;
    end else begin
      if (rd_en_c) d_out <= rdata_c;

      case (state)
        IDLE: begin
          if (wr_en_c) begin
            case (addr)
              ADDR_A: a_reg <= d_in[W-1:0];
              ADDR_B: b_reg <= d_in[W-1:0];
              ADDR_CTRL: begin
                if (d_in[2]) begin
                  done <= 1'b0;
                  err  <= 1'b0;
                end
                if (d_in[0]) begin
                  done     <= 1'b0;
                  mcand    <= a_mag_c;
                  acc      <= {{W{1'b0}}, b_mag_c};
                  count    <= '0;
                  sgn_mode <= start_sgn_c;
                  neg      <= start_sgn_c & (a_reg[W-1] ^ b_reg[W-1]);
                  state    <= CALC;
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc   <= {sum_c, acc[W-1:1]};
          count <= count + 1'b1;
          if (count == CW'(W - 1)) state <= FINISH;
        end
        FINISH: begin
          res   <= res_ext_c;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Register writes while the engine is running are dropped and flagged
      if (busy_c && reg_wr_c) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_peripheral_mult_n.sv
// Bench for peripheral_mult_n: W=16 and W=32 instances on a shared bus,
// expected products queued at start and compared when the DUT reports done.
module tb_peripheral_mult_n;

  localparam logic [4:0] A_A = 5'h04, A_B = 5'h08, A_CTRL = 5'h0C;
  localparam logic [4:0] A_LO = 5'h10, A_HI = 5'h14, A_ST = 5'h18;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, cs16, cs32, rd, wr;
  logic [4:0]  addr;
  logic [31:0] d_in, dout16, dout32;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  peripheral_mult_n #(.W(16)) dut16 (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs16), .addr(addr),
    .rd(rd), .wr(wr), .d_out(dout16)
  );

  peripheral_mult_n #(.W(32)) dut32 (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs32), .addr(addr),
    .rd(rd), .wr(wr), .d_out(dout32)
  );

  function automatic logic [63:0] model(input int w, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ea, eb;
    mask = (64'd1 << w) - 64'd1;
    ea = {32'b0, a} & mask;
    eb = {32'b0, b} & mask;
    if (sgn) begin
      if (ea[w-1]) ea = ea | ~mask;
      if (eb[w-1]) eb = eb | ~mask;
    end
    return ea * eb;
  endfunction

  task automatic wr_reg(input bit sel, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs16 = !sel; cs32 = sel; addr = a; d_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; cs16 = 1'b0; cs32 = 1'b0;
  endtask

  task automatic rd_reg(input bit sel, input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs16 = !sel; cs32 = sel; addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0; cs16 = 1'b0; cs32 = 1'b0;
    d = sel ? dout32 : dout16;
  endtask

  task automatic start_op(input bit sel, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    wr_reg(sel, A_A, a);
    wr_reg(sel, A_B, b);
    wr_reg(sel, A_CTRL, {30'b0, sgn, 1'b1});
    p = model(sel ? 32 : 16, sgn, a, b);
    sb.push_back('{lo: p[31:0], hi: p[63:32]});
  endtask

  // Streams STATUS reads every cycle until done is seen
  task automatic poll_done(input bit sel, output int busy_n, output logic [31:0] st);
    bit got;
    busy_n = 0; got = 1'b0; st = '0;
    cs16 = !sel; cs32 = sel; addr = A_ST; rd = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      st = sel ? dout32 : dout16;
      if (st[0]) busy_n++;
      if (st[1]) got = 1'b1;
    end
    rd = 1'b0; cs16 = 1'b0; cs32 = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL poll_timeout sel=%0d status=%h required done=1", sel, st);
    end
  endtask

  task automatic collect(input bit sel, output logic [31:0] lo, output logic [31:0] hi, output exp_t e);
    rd_reg(sel, A_LO, lo);
    rd_reg(sel, A_HI, hi);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{lo: 'x, hi: 'x};
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [4:0]  regs [6] = '{A_A, A_B, A_CTRL, A_LO, A_HI, A_ST};
    reset = 1'b1; cs16 = 0; cs32 = 0; rd = 0; wr = 0; addr = '0; d_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (dout16 !== 32'h0 || dout32 !== 32'h0) begin
      n_fail++; $display("FAIL reset_dout got=%h/%h required=0", dout16, dout32);
    end
    foreach (regs[i]) begin
      rd_reg(1'b0, regs[i], v);
      n_checks++;
      if (v !== 32'h0) begin
        n_fail++; $display("FAIL reset_reg addr=%h got=%h required=0", regs[i], v);
      end
    end
  endtask

  task automatic test_mult(input string name, input bit sel, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b);
    int busy_n; logic [31:0] st, lo, hi, st2; exp_t e;
    start_op(sel, sgn, a, b);
    poll_done(sel, busy_n, st);
    n_checks++;
    if (busy_n !== (sel ? 33 : 17)) begin
      n_fail++; $display("FAIL %s_busy_cycles got=%0d required=%0d", name, busy_n, sel ? 33 : 17);
    end
    n_checks++;
    if (st !== 32'h2) begin
      n_fail++; $display("FAIL %s_status got=%h required=00000002", name, st);
    end
    collect(sel, lo, hi, e);
    n_checks++;
    if (lo !== e.lo || hi !== e.hi) begin
      n_fail++; $display("FAIL %s_result got=%h_%h required=%h_%h", name, hi, lo, e.hi, e.lo);
    end
    rd_reg(sel, A_ST, st2);
    n_checks++;
    if (st2 !== 32'h2) begin
      n_fail++; $display("FAIL %s_status_sticky got=%h required=00000002", name, st2);
    end
  endtask

  task automatic test_readback();
    logic [31:0] v;
    wr_reg(1'b0, A_A, 32'h0001_2345);
    rd_reg(1'b0, A_A, v);
    n_checks++;
    if (v !== 32'h0000_2345) begin
      n_fail++; $display("FAIL readback_a got=%h required=00002345", v);
    end
    wr_reg(1'b0, A_B, 32'hABCD_EF01);
    rd_reg(1'b0, A_B, v);
    n_checks++;
    if (v !== 32'h0000_EF01) begin
      n_fail++; $display("FAIL readback_b got=%h required=0000ef01", v);
    end
    wr_reg(1'b0, 5'h1C, 32'hFFFF_FFFF);
    rd_reg(1'b0, 5'h1C, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL readback_unmapped got=%h required=0", v);
    end
    rd_reg(1'b0, A_CTRL, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL readback_ctrl got=%h required=0", v);
    end
  endtask

  task automatic test_busy_write();
    int busy_n; logic [31:0] st, lo, hi, v; exp_t e;
    start_op(1'b0, 1'b0, 32'd3, 32'd4);
    wr_reg(1'b0, A_A, 32'd9);
    wr_reg(1'b0, A_CTRL, 32'h1);
    poll_done(1'b0, busy_n, st);
    n_checks++;
    if (st !== 32'h6) begin
      n_fail++; $display("FAIL busy_write_status got=%h required=00000006", st);
    end
    collect(1'b0, lo, hi, e);
    n_checks++;
    if (lo !== e.lo || hi !== e.hi) begin
      n_fail++; $display("FAIL busy_write_result got=%h_%h required=%h_%h", hi, lo, e.hi, e.lo);
    end
    rd_reg(1'b0, A_A, v);
    n_checks++;
    if (v !== 32'd3) begin
      n_fail++; $display("FAIL busy_write_a_kept got=%h required=00000003", v);
    end
    wr_reg(1'b0, A_CTRL, 32'h4);
    rd_reg(1'b0, A_ST, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL busy_write_clr got=%h required=0", v);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n; logic [31:0] st, lo, hi; exp_t e; logic [63:0] p;
    start_op(1'b0, 1'b0, 32'h8001, 32'h0003);
    repeat (16) @(negedge clk);
    // Start lands on the edge right after done rises
    wr_reg(1'b0, A_CTRL, 32'h3);
    p = model(16, 1'b1, 32'h8001, 32'h0003);
    sb.push_back('{lo: p[31:0], hi: p[63:32]});
    collect(1'b0, lo, hi, e);
    n_checks++;
    if (lo !== e.lo || hi !== e.hi) begin
      n_fail++; $display("FAIL b2b_first_result got=%h_%h required=%h_%h", hi, lo, e.hi, e.lo);
    end
    poll_done(1'b0, busy_n, st);
    n_checks++;
    if (st !== 32'h2) begin
      n_fail++; $display("FAIL b2b_status got=%h required=00000002", st);
    end
    collect(1'b0, lo, hi, e);
    n_checks++;
    if (lo !== e.lo || hi !== e.hi) begin
      n_fail++; $display("FAIL b2b_second_result got=%h_%h required=%h_%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++)
      test_mult("random", 1'b0, 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [4:0]  regs [3] = '{A_ST, A_LO, A_HI};
    start_op(1'b0, 1'b0, 32'd7, 32'd9);
    rd_reg(1'b0, A_ST, v);
    n_checks++;
    if (v !== 32'h1) begin
      n_fail++; $display("FAIL reset_mid_busy got=%h required=00000001", v);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    n_checks++;
    if (dout16 !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_dout got=%h required=0", dout16);
    end
    foreach (regs[i]) begin
      rd_reg(1'b0, regs[i], v);
      n_checks++;
      if (v !== 32'h0) begin
        n_fail++; $display("FAIL reset_mid_reg addr=%h got=%h required=0", regs[i], v);
      end
    end
    test_mult("after_reset", 1'b0, 1'b1, 32'hFFF9, 32'h0006);
  endtask

  initial begin
    test_reset();
    test_mult("unsigned16", 1'b0, 1'b0, 32'hFFFF, 32'hFFFF);
    test_mult("signed16", 1'b0, 1'b1, 32'hFFFD, 32'h0005);
    test_mult("signed_corner", 1'b0, 1'b1, 32'h8000, 32'h8000);
    test_mult("unsigned32", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_mult("signed32", 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0007);
    test_readback();
    test_busy_write();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/peripheral_mult_n.md
# peripheral_mult_n

Memory-mapped, parametrised sequential multiplier peripheral on the J1 I/O bus. It is the next-generation multiplier peripheral: configurable operand width, signed/unsigned mode, a full-width result split over two 32-bit words, and a busy/done/error status word. Firmware writes the operands, starts the operation through a control register, polls status, then reads the product. The multiplier is an internal radix-2 shift-add engine.

## Interface
- `W`, default 16: operand width in bits. Legal range is 4..32. The product is 2·W bits.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `reset` input, 1 bit: reset, synchronous, active-high. Clock is `clk`.
- `d_in` input, 32 bits: write data. Operand registers take `d_in[W-1:0]`.
- `cs` input, 1 bit: peripheral chip select.
- `addr` input, 5 bits: register address, low bits of the J1 I/O address.
- `rd` input, 1 bit: read strobe, qualified by `cs`.
- `wr` input, 1 bit: write strobe, qualified by `cs`.
- `d_out` output, 32 bits: registered read data. Reset value is 0.

## Operation
**Register map:**
- 0x04 A: read/write, W bits.
- 0x08 B: read/write, W bits.
- 0x0C CTRL: write-only, reads 0.
  - bit0 `start`.
  - bit1 `signed` mode.
  - bit2 `clr`, which clears `done` and `err`.
- 0x10 RES_LO: read-only.
- 0x14 RES_HI: read-only.
- 0x18 STATUS: read-only, `{29'b0, err, done, busy}`.
- Any other address reads 0; writes to it are ignored.

**Result format:**
- The product is sign-extended (signed mode) or zero-extended (unsigned mode) to 64 bits.
- RES_LO = bits[31:0]; RES_HI = bits[63:32].

**State machine:** IDLE → CALC → FINISH → IDLE.
- IDLE
  - A CTRL write with `start`=1 latches A, B and the mode into internal working registers.
  - It clears `done` and the accumulator, loads counter = 0, and moves to CALC.
- CALC
  - Works on operand magnitudes: in signed mode a negative operand is two's-complemented first. Most-negative values are handled as a W-bit unsigned magnitude.
  - Each cycle: if multiplier LSB = 1, add the multiplicand to the accumulator upper half; then shift right by one.
  - Runs exactly W cycles, then goes to FINISH.
- FINISH
  - Negates the 2W-bit product if signed mode is set and the operand signs differ.
  - Writes the result registers and sets `done`=1, then goes to IDLE.
- `busy` = 1 in CALC and FINISH.

**Write rules:**
- While `busy`=1, writes to A, B or CTRL are ignored and set sticky `err`=1. This includes a `start` while busy.
- A CTRL write in IDLE with both `clr` and `start` set first clears `err`/`done`, then starts.
- A CTRL write with `start`=0 and `clr`=1 only clears the flags.
- Reading STATUS does not clear any flag.
- RES_LO/RES_HI hold their last value until the next FINISH. They stay readable during CALC and show the previous result.

**Reset:**
- Reset clears A, B, the result, the working registers, `done`, `err` and `d_out`, and forces IDLE.
- Reset mid-operation aborts with no result update.

## Timing
- Start latency:
  - The CTRL start write is sampled at edge T.
  - `busy` reads 1 from the cycle after T.
  - FINISH executes at edge T+W+1.
  - `done`=1 and the result are valid after edge T+W+1, i.e. W+1 cycles after the start edge.
- `busy` returns to 0 on the same edge that `done` rises.
- Read latency:
  - `d_out` loads on the edge where `cs && rd`; data is valid one cycle after the strobe.
  - `d_out` holds its value when no read is in progress.
- A read of STATUS on the same edge that FINISH executes returns the pre-edge values (`busy`=1, `done`=0).
- A write to A or B in IDLE takes effect at the sampling edge. It is readable back on the next read, with upper bits zero.
- Back-to-back operations: a start written on the cycle after `done` rises is accepted, giving a throughput of W+2 cycles.

## Test plan
- **Unsigned, W=16:** A=0xFFFF, B=0xFFFF, start → `busy` for exactly 17 cycles; RES_LO=0xFFFE0001, RES_HI=0, STATUS=0b010.
- **Signed, W=16:** A=0xFFFD (−3), B=0x0005, CTRL=0b011 → RES_LO=0xFFFFFFF1, RES_HI=0xFFFFFFFF.
- **Signed corner, W=16:** A=B=0x8000 → RES_LO=0x40000000, RES_HI=0.
- **W=32 unsigned:** A=B=0xFFFFFFFF → RES_HI=0xFFFFFFFE, RES_LO=0x00000001, latency 33 cycles.
- **Write during busy:** start with A=3, B=4, then write A=9 at cycle 2 → result 12, STATUS=0b110. CTRL `clr` → STATUS=0b000.
- **Reset mid-operation:** reset asserted at cycle 5 of CALC → STATUS=0, RES_LO/RES_HI=0, `d_out`=0. A new start then completes normally.
